// File: rtl/systolic_commutator.sv
// systolic_commutator: TAPS-deep sample delay line feeding an external PE array.
// PE results are commutated onto one output word in rotation. Tracks line fill,
// enforces a minimum spacing between accepted donext pulses, and flags overruns.
module systolic_commutator #(
  parameter int unsigned WORDLENGTH = 16,
  parameter int unsigned TAPS       = 8,
  parameter int unsigned MIN_GAP    = 18
) (
  input  logic                         clk30x,
  input  logic                         reset,
  input  logic [WORDLENGTH-1:0]        inputword,
  input  logic                         donext,
  input  logic                         clr_overrun,
  output logic [TAPS*WORDLENGTH-1:0]   pe_in,
  input  logic [TAPS*WORDLENGTH-1:0]   pe_out,
  output logic                         pe_donext,
  output logic [WORDLENGTH-1:0]        outputword,
  output logic                         out_strobe,
  output logic                         out_valid,
  output logic [WORDLENGTH-1:0]        inputword_delayed,
  output logic                         overrun
);

  localparam int unsigned IDXW  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned GAPW  = $clog2(MIN_GAP + 1);
  localparam int unsigned FILLW = $clog2(TAPS + 2);

  logic [TAPS-1:0][WORDLENGTH-1:0] taps_q, taps_d;
  logic [IDXW-1:0]                 widx_q, widx_d;
  logic [GAPW-1:0]                 gap_q, gap_d;
  logic [FILLW-1:0]                fill_q, fill_d;
  logic [WORDLENGTH-1:0]           outword_q, outword_d;
  logic                            strobe_q, strobe_d;
  logic                            valid_q, valid_d;
  logic                            overrun_q, overrun_d;

  logic                            accept_c;
  logic                            reject_c;
  logic [IDXW-1:0]                 sel_c;
  logic [WORDLENGTH-1:0]           sel_word_c;

  // Accept only once the spacing counter has reached the minimum gap.
  assign accept_c  = donext & (gap_q >= GAPW'(MIN_GAP));
  assign reject_c  = donext & ~accept_c;
  assign pe_donext = accept_c;

  // Next PE to commutate; explicit wrap so non-power-of-2 TAPS works.
  assign sel_c = (widx_q == IDXW'(TAPS - 1)) ? '0 : widx_q + IDXW'(1);

  // Constant-index mux over the flat PE result bus.
  always_comb begin
    sel_word_c = '0;
    for (int k = 0; k < int'(TAPS); k++) begin
      if (sel_c == IDXW'(k)) sel_word_c = pe_out[k*WORDLENGTH +: WORDLENGTH];
    end
  end

  // Next-state logic for delay line, commutator, fill, spacing and overrun.
  always_comb begin
    taps_d    = taps_q;
    widx_d    = widx_q;
    gap_d     = gap_q;
    fill_d    = fill_q;
    outword_d = outword_q;
    strobe_d  = 1'b0;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (accept_c) begin
      taps_d    = {taps_q[TAPS-2:0], inputword};
      widx_d    = sel_c;
      outword_d = sel_word_c;
      strobe_d  = 1'b1;
      gap_d     = GAPW'(1);
      if (fill_q < FILLW'(TAPS + 1)) fill_d = fill_q + FILLW'(1);
      if (fill_q == FILLW'(TAPS))    valid_d = 1'b1;
    end else if (gap_q < GAPW'(MIN_GAP)) begin
      gap_d = gap_q + GAPW'(1);
    end

    // A rejection in the same cycle as a clear keeps the flag set.
    if (reject_c)         overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk30x) begin
    if (reset) begin
      taps_q    <= '0;
      widx_q    <= IDXW'(TAPS - 1);
      gap_q     <= GAPW'(MIN_GAP);
      fill_q    <= '0;
      outword_q <= '0;
      strobe_q  <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      taps_q    <= taps_d;
      widx_q    <= widx_d;
      gap_q     <= gap_d;
      fill_q    <= fill_d;
      outword_q <= outword_d;
      strobe_q  <= strobe_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign pe_in             = taps_q;
  assign inputword_delayed = taps_q[TAPS-1];
  assign outputword        = outword_q;
  assign out_strobe        = strobe_q;
  assign out_valid         = valid_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_systolic_commutator.sv
// Bench for systolic_commutator: an 8-tap and a 5-tap instance, directed stimulus,
// expected output words queued on accept and checked at each out_strobe.
module tb_systolic_commutator;

  localparam int unsigned W  = 16;
  localparam int unsigned T8 = 8;
  localparam int unsigned T5 = 5;

  typedef struct {
    logic [W-1:0] word;
    logic         valid;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  exp_t q8[$];
  exp_t q5[$];

  // 8-tap instance signals
  logic              reset8, donext8, clr8;
  logic [W-1:0]      inword8;
  logic [T8*W-1:0]   pe_in8, pe_out8;
  logic              pe_donext8, strobe8, valid8, overrun8;
  logic [W-1:0]      outword8, delayed8;

  // 5-tap instance signals
  logic              reset5, donext5, clr5;
  logic [W-1:0]      inword5;
  logic [T5*W-1:0]   pe_in5, pe_out5;
  logic              pe_donext5, strobe5, valid5, overrun5;
  logic [W-1:0]      outword5, delayed5;

  systolic_commutator #(.WORDLENGTH(W), .TAPS(T8), .MIN_GAP(18)) u_dut8 (
    .clk30x(clk), .reset(reset8), .inputword(inword8), .donext(donext8),
    .clr_overrun(clr8), .pe_in(pe_in8), .pe_out(pe_out8), .pe_donext(pe_donext8),
    .outputword(outword8), .out_strobe(strobe8), .out_valid(valid8),
    .inputword_delayed(delayed8), .overrun(overrun8)
  );

  systolic_commutator #(.WORDLENGTH(W), .TAPS(T5), .MIN_GAP(18)) u_dut5 (
    .clk30x(clk), .reset(reset5), .inputword(inword5), .donext(donext5),
    .clr_overrun(clr5), .pe_in(pe_in5), .pe_out(pe_out5), .pe_donext(pe_donext5),
    .outputword(outword5), .out_strobe(strobe5), .out_valid(valid5),
    .inputword_delayed(delayed5), .overrun(overrun5)
  );

  // Bench-side model of the commutator position and fill count.
  int sel8 = 0, fill8 = 0, sel5 = 0, fill5 = 0;

  task automatic chk(input string tag, input logic [T8*W-1:0] obs, input logic [T8*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic push8();
    exp_t e;
    fill8++;
    e.word  = W'(16'h100 + sel8);
    e.valid = (fill8 >= int'(T8) + 1);
    q8.push_back(e);
    sel8 = (sel8 + 1) % int'(T8);
  endtask

  task automatic push5();
    exp_t e;
    fill5++;
    e.word  = W'(16'h200 + sel5);
    e.valid = (fill5 >= int'(T5) + 1);
    q5.push_back(e);
    sel5 = (sel5 + 1) % int'(T5);
  endtask

  // One-cycle donext pulse on the 8-tap instance with expected accept outcome.
  task automatic next8(input logic [W-1:0] word, input logic exp_acc);
    inword8 = word;
    donext8 = 1'b1;
    #1;
    chk("pe_donext8", (T8*W)'(pe_donext8), (T8*W)'(exp_acc));
    if (exp_acc) push8();
    @(posedge clk);
    #1;
    donext8 = 1'b0;
  endtask

  task automatic next5(input logic [W-1:0] word, input logic exp_acc);
    inword5 = word;
    donext5 = 1'b1;
    #1;
    chk("pe_donext5", (T8*W)'(pe_donext5), (T8*W)'(exp_acc));
    if (exp_acc) push5();
    @(posedge clk);
    #1;
    donext5 = 1'b0;
  endtask

  // Strobe monitors: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (strobe8) begin
      chk("strobe8_expected", (T8*W)'(q8.size() != 0), (T8*W)'(1));
      if (q8.size() != 0) begin
        exp_t e;
        e = q8.pop_front();
        chk("outputword8", (T8*W)'(outword8), (T8*W)'(e.word));
        chk("out_valid8", (T8*W)'(valid8), (T8*W)'(e.valid));
      end
    end
  end

  always @(negedge clk) begin
    if (strobe5) begin
      chk("strobe5_expected", (T8*W)'(q5.size() != 0), (T8*W)'(1));
      if (q5.size() != 0) begin
        exp_t e;
        e = q5.pop_front();
        chk("outputword5", (T8*W)'(outword5), (T8*W)'(e.word));
        chk("out_valid5", (T8*W)'(valid5), (T8*W)'(e.valid));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [T8*W-1:0] exp_bus;
    logic [T8*W-1:0] saved_taps;
    logic [W-1:0]    saved_out;

    reset8 = 1'b1; donext8 = 1'b0; clr8 = 1'b0; inword8 = '0;
    reset5 = 1'b1; donext5 = 1'b0; clr5 = 1'b0; inword5 = '0;
    for (int k = 0; k < int'(T8); k++) pe_out8[k*W +: W] = W'(16'h100 + k);
    for (int k = 0; k < int'(T5); k++) pe_out5[k*W +: W] = W'(16'h200 + k);

    // Reset state of the 8-tap instance.
    idle(3);
    reset8 = 1'b0;
    chk("rst_pe_in8", pe_in8, '0);
    chk("rst_outword8", (T8*W)'(outword8), '0);
    chk("rst_delayed8", (T8*W)'(delayed8), '0);
    chk("rst_strobe8", (T8*W)'(strobe8), '0);
    chk("rst_valid8", (T8*W)'(valid8), '0);
    chk("rst_overrun8", (T8*W)'(overrun8), '0);

    // Fill the line with 1..8 spaced 20 cycles apart.
    for (int i = 1; i <= 8; i++) begin
      next8(W'(i), 1'b1);
      if (i != 8) idle(19);
    end
    for (int k = 0; k < int'(T8); k++) exp_bus[k*W +: W] = W'(8 - k);
    chk("fill_pe_in8", pe_in8, exp_bus);
    chk("fill_delayed8", (T8*W)'(delayed8), (T8*W)'(1));
    chk("fill_valid8", (T8*W)'(valid8), '0);

    // Continue commutation at the minimum spacing of 18 cycles.
    for (int i = 9; i <= 12; i++) begin
      idle(17);
      next8(W'(i), 1'b1);
    end
    chk("valid_after_fill8", (T8*W)'(valid8), (T8*W)'(1));

    // Gap violation 10 cycles after an accept.
    idle(17);
    next8(W'(13), 1'b1);
    idle(9);
    saved_taps = pe_in8;
    saved_out  = outword8;
    next8(W'(16'hdead), 1'b0);
    chk("rej_taps8", pe_in8, saved_taps);
    chk("rej_outword8", (T8*W)'(outword8), (T8*W)'(saved_out));
    chk("rej_overrun8", (T8*W)'(overrun8), (T8*W)'(1));
    clr8 = 1'b1;
    cycle();
    clr8 = 1'b0;
    chk("clr_overrun8", (T8*W)'(overrun8), '0);
    clr8 = 1'b1;
    next8(W'(16'hbeef), 1'b0);
    clr8 = 1'b0;
    chk("set_wins8", (T8*W)'(overrun8), (T8*W)'(1));
    clr8 = 1'b1;
    cycle();
    clr8 = 1'b0;
    chk("clr_again8", (T8*W)'(overrun8), '0);

    // donext held for three cycles: one accept, two rejections.
    idle(20);
    inword8 = W'(16'h55);
    donext8 = 1'b1;
    #1;
    chk("held_c0_8", (T8*W)'(pe_donext8), (T8*W)'(1));
    push8();
    @(posedge clk); #1;
    chk("held_c1_8", (T8*W)'(pe_donext8), '0);
    @(posedge clk); #1;
    chk("held_c2_8", (T8*W)'(pe_donext8), '0);
    @(posedge clk); #1;
    donext8 = 1'b0;
    chk("held_overrun8", (T8*W)'(overrun8), (T8*W)'(1));
    chk("held_tap0_8", (T8*W)'(pe_in8[W-1:0]), (T8*W)'(16'h55));
    idle(4);
    chk("q8_drained", (T8*W)'(q8.size()), '0);

    // 5-tap instance: six accepts wrap the selection back to PE0.
    reset5 = 1'b0;
    chk("rst_outword5", (T8*W)'(outword5), '0);
    for (int i = 1; i <= 6; i++) begin
      next5(W'(i), 1'b1);
      idle(17);
    end
    chk("valid5_after6", (T8*W)'(valid5), (T8*W)'(1));
    chk("delayed5", (T8*W)'(delayed5), (T8*W)'(2));

    // Reset mid-run after three more accepts.
    for (int i = 7; i <= 9; i++) begin
      next5(W'(i), 1'b1);
      if (i != 9) idle(17);
    end
    reset5 = 1'b1;
    cycle();
    reset5 = 1'b0;
    sel5 = 0;
    fill5 = 0;
    chk("mid_rst_pe_in5", (T8*W)'(pe_in5), '0);
    chk("mid_rst_outword5", (T8*W)'(outword5), '0);
    chk("mid_rst_valid5", (T8*W)'(valid5), '0);
    chk("mid_rst_overrun5", (T8*W)'(overrun5), '0);
    next5(W'(16'h77), 1'b1);
    chk("post_rst_outword5", (T8*W)'(outword5), (T8*W)'(16'h200));
    chk("post_rst_tap0_5", (T8*W)'(pe_in5[W-1:0]), (T8*W)'(16'h77));
    idle(4);
    chk("q5_drained", (T8*W)'(q5.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_commutator.md
Name: systolic_commutator

Overview:
- Parametrised successor of the 8-point systolic interpolator wrapper.
- Holds a TAPS-deep input delay line that feeds TAPS external processing elements (PEs) over flat buses, and commutates the PE results onto one output in rotation.
- Adds fill tracking (out_valid), an output strobe, and enforcement of the minimum donext spacing with a sticky overrun flag.
- Sits between the sample source and the PE array; the PEs are instantiated alongside it, not inside it.

Parameters:
- WORDLENGTH, 16, bits per sample and per PE result.
- TAPS, 8, number of delay taps and PEs; any value >= 2, power of 2 not required.
- MIN_GAP, 18, minimum clk30x cycles between accepted donext pulses (16 for the multiply plus 2); must be >= 1.

Ports:
- clk30x  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- inputword  in  WORDLENGTH  new sample, captured on an accepted donext.
- donext  in  1  advance request; nominally a 1-cycle pulse.
- clr_overrun  in  1  clears the sticky overrun flag.
- pe_in  out  TAPS*WORDLENGTH  tap k at bits [k*WORDLENGTH +: WORDLENGTH].
- pe_out  in  TAPS*WORDLENGTH  result of PE k, same slicing.
- pe_donext  out  1  combinational accept pulse to all PEs.
- outputword  out  WORDLENGTH  commutated interpolated value.
- out_strobe  out  1  1-cycle pulse when outputword updates.
- out_valid  out  1  line filled, outputword meaningful.
- inputword_delayed  out  WORDLENGTH  tap TAPS-1.
- overrun  out  1  sticky: a donext was rejected.

Behaviour:
- Accept rule: accept = donext & (gap_cnt >= MIN_GAP); pe_donext = accept, with no register.
- gap_cnt:
  - Resets to MIN_GAP, so the first donext after reset is accepted.
  - Loads 1 on an accept cycle; otherwise increments, saturating at MIN_GAP.
  - Result: accepts are spaced at least MIN_GAP cycles apart.
- Rejected donext (donext & !accept):
  - No change to taps, wordIndex, fill or outputword; out_strobe stays 0.
  - Sets overrun.
  - If clr_overrun is asserted in the same cycle, set wins.
- Delay line on accept: tap[0] <= inputword; tap[k] <= tap[k-1] for k = 1..TAPS-1. pe_in and inputword_delayed are driven directly from the tap registers.
- wordIndex:
  - Width clog2(TAPS).
  - Resets to TAPS-1.
  - On accept: increments, wrapping from TAPS-1 to 0 explicitly, so non-power-of-2 TAPS is handled.
- Output commutation:
  - On accept: outputword <= pe_out slice sel, where sel = (wordIndex+1) mod TAPS, using the pre-increment wordIndex.
  - Selection order after reset: PE0, PE1, ..., PE(TAPS-1), PE0, ...
- out_strobe: registered; equals 1 in the cycle after an accept, 0 otherwise.
- fill_cnt:
  - Counts accepts, saturating at TAPS+1.
  - out_valid is registered and goes 1 in the cycle after the accept that brings fill_cnt to TAPS+1, i.e. together with the out_strobe of the (TAPS+1)-th accept.
  - Stays 1 until reset.
- Reset values: taps 0, pe_in 0, inputword_delayed 0, outputword 0, out_strobe 0, out_valid 0, overrun 0, wordIndex TAPS-1, fill_cnt 0, gap_cnt MIN_GAP.
- Reset mid-operation:
  - Everything returns to the reset values on the next edge, including gap_cnt = MIN_GAP.
  - Reset has priority over donext and clr_overrun.
- donext held high for several cycles: only the first cycle is accepted; the remaining cycles fall inside the gap window, are rejected, and set overrun.
- Latency: inputword reaches tap[0], and an accepted selection reaches outputword, one edge after accept.

Test Plan:
- Reset, TAPS=8: pulse reset -> all outputs 0, overrun 0, first donext accepted (pe_donext=1 on that cycle).
- Fill the line: inputword 1..8, donext every 20 cycles -> after the 8th accept pe_in tap k = 8-k, inputword_delayed = 1, out_valid still 0.
- Commutation: pe_out slice k held at 0x100+k; 10 accepts spaced 18 cycles apart -> outputword 0x100..0x107, 0x100, 0x101, one out_strobe per accept, out_valid = 1 starting with the 9th strobe.
- Gap violation: accept, then donext 10 cycles later -> pe_donext 0, taps and outputword unchanged, overrun = 1. Assert clr_overrun -> overrun = 0. Assert clr_overrun together with a rejected donext -> overrun stays 1.
- donext held 3 cycles -> exactly one accept, one out_strobe, overrun = 1.
- TAPS=5 build, plus reset mid-run:
  - Six accepts -> select order PE0..PE4, PE0; wordIndex wraps 4 -> 0.
  - Reset after 3 accepts -> state cleared; next donext accepted and selects PE0.
